// File: rtl/fir_mac_seq_ctrl.sv
// Address/strobe sequencer for a single-MAC FIR with multi-channel sample banks.
// Optional FIR_SYM_FOLD_EN: symmetric folding, two data reads per tap and half-length sweeps.
module fir_mac_seq_ctrl #(
    parameter int TAPS    = 16,
    parameter int CH      = 1,
    parameter int MAC_LAT = 2,
    localparam int AW     = $clog2(TAPS),
    localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              Clk_i,
    input  logic              RstN_i,
    input  logic              DataNd_i,
    input  logic [CHW-1:0]    DataCh_i,
    output logic              Ready_o,
    output logic              DataWe_o,
    output logic [CHW+AW-1:0] DataAddrWr_o,
    output logic [CHW+AW-1:0] DataAddr_o,
`ifdef FIR_SYM_FOLD_EN
    output logic [CHW+AW-1:0] DataAddrB_o,
`endif
    output logic [AW-1:0]     CoeffAddr_o,
    output logic              AddrValid_o,
    output logic              StartAcc_o,
    output logic              DataValid_o,
    output logic [CHW-1:0]    DataCh_o,
    output logic              Overrun_o
);

`ifdef FIR_SYM_FOLD_EN
    localparam int NT = TAPS / 2;
`else
    localparam int NT = TAPS;
`endif
    localparam int NB = 1 << CHW;
    localparam logic [AW-1:0] LAST = AW'(NT - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [AW-1:0]    r_wptr [NB];
    logic [CHW-1:0]   r_ch;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_tap;
    logic             r_addr_valid;
    logic             r_overrun;
    logic [MAC_LAT-1:0] r_start_pipe;
    logic [MAC_LAT:0]   r_last_pipe;
    logic [CHW-1:0]   r_ch_pipe [MAC_LAT+1];
`ifdef FIR_SYM_FOLD_EN
    logic [AW-1:0]    r_rdb;
`endif

    logic             w_last;
    logic             w_first;
    logic             w_acc;
    logic [AW-1:0]    w_wptr_cur;

    assign w_last     = (r_state == S_RUN) && (r_tap == LAST);
    assign w_first    = r_addr_valid && (r_tap == '0);
    assign Ready_o    = (r_state == S_IDLE) || w_last;
    assign w_acc      = DataNd_i && Ready_o;
    assign w_wptr_cur = r_wptr[DataCh_i];

    assign DataWe_o     = w_acc;
    assign DataAddrWr_o = {DataCh_i, w_wptr_cur};
    assign DataAddr_o   = {r_ch, r_rd};
    assign CoeffAddr_o  = r_tap;
    assign AddrValid_o  = r_addr_valid;
    assign Overrun_o    = r_overrun;
    assign StartAcc_o   = r_start_pipe[MAC_LAT-1];
    assign DataValid_o  = r_last_pipe[MAC_LAT];
    assign DataCh_o     = r_ch_pipe[MAC_LAT];
`ifdef FIR_SYM_FOLD_EN
    assign DataAddrB_o  = {r_ch, r_rdb};
`endif

    // Sweep FSM; rd walks newest->oldest, tap doubles as the coefficient address.
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_rd         <= '0;
            r_tap        <= '0;
            r_addr_valid <= 1'b0;
`ifdef FIR_SYM_FOLD_EN
            r_rdb        <= '0;
`endif
        end else if (w_acc) begin
            r_state      <= S_RUN;
            r_ch         <= DataCh_i;
            r_rd         <= w_wptr_cur;
            r_tap        <= '0;
            r_addr_valid <= 1'b1;
`ifdef FIR_SYM_FOLD_EN
            r_rdb        <= w_wptr_cur - AW'(TAPS - 1);
`endif
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                r_state      <= S_IDLE;
                r_addr_valid <= 1'b0;
            end else begin
                r_tap <= r_tap + ONE;
                r_rd  <= r_rd - ONE;
`ifdef FIR_SYM_FOLD_EN
                r_rdb <= r_rdb + ONE;
`endif
            end
        end
    end

    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            for (int i = 0; i < NB; i++) r_wptr[i] <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_acc) r_wptr[DataCh_i] <= w_wptr_cur + ONE;
            r_overrun <= DataNd_i && !Ready_o;
        end
    end

    // Strobe delay lines; per-stage state so overlapping sweeps never collide.
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            r_start_pipe <= '0;
            r_last_pipe  <= '0;
            for (int i = 0; i <= MAC_LAT; i++) r_ch_pipe[i] <= '0;
        end else begin
            r_start_pipe[0] <= w_first;
            for (int i = 1; i < MAC_LAT; i++) r_start_pipe[i] <= r_start_pipe[i-1];
            r_last_pipe[0] <= w_last;
            r_ch_pipe[0]   <= r_ch;
            for (int i = 1; i <= MAC_LAT; i++) begin
                r_last_pipe[i] <= r_last_pipe[i-1];
                r_ch_pipe[i]   <= r_ch_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_seq_ctrl.sv
// Scoreboard bench for fir_mac_seq_ctrl (TAPS=16, CH=4, MAC_LAT=2); also covers FIR_SYM_FOLD_EN builds.
module tb_fir_mac_seq_ctrl;
    localparam int TAPS = 16, CH = 4, MAC_LAT = 2, AW = 4, CHW = 2;
`ifdef FIR_SYM_FOLD_EN
    localparam int NT = TAPS / 2;
`else
    localparam int NT = TAPS;
`endif

    logic Clk_i = 0, RstN_i = 0, DataNd_i = 0;
    logic [CHW-1:0] DataCh_i = 0;
    logic Ready_o, DataWe_o, AddrValid_o, StartAcc_o, DataValid_o, Overrun_o;
    logic [CHW+AW-1:0] DataAddrWr_o, DataAddr_o;
    logic [AW-1:0] CoeffAddr_o;
    logic [CHW-1:0] DataCh_o;
`ifdef FIR_SYM_FOLD_EN
    logic [CHW+AW-1:0] DataAddrB_o;
`endif

    fir_mac_seq_ctrl #(.TAPS(TAPS), .CH(CH), .MAC_LAT(MAC_LAT)) dut (
        .Clk_i(Clk_i), .RstN_i(RstN_i), .DataNd_i(DataNd_i), .DataCh_i(DataCh_i),
        .Ready_o(Ready_o), .DataWe_o(DataWe_o), .DataAddrWr_o(DataAddrWr_o),
        .DataAddr_o(DataAddr_o),
`ifdef FIR_SYM_FOLD_EN
        .DataAddrB_o(DataAddrB_o),
`endif
        .CoeffAddr_o(CoeffAddr_o), .AddrValid_o(AddrValid_o), .StartAcc_o(StartAcc_o),
        .DataValid_o(DataValid_o), .DataCh_o(DataCh_o), .Overrun_o(Overrun_o));

    always #5 Clk_i = ~Clk_i;

    typedef struct { int cyc; logic [5:0] a; logic [5:0] b; logic [3:0] c; } addr_t;
    typedef struct { int cyc; logic [1:0] ch; } res_t;

    addr_t addr_q[$];
    int    start_q[$];
    res_t  res_q[$];
    int    ovr_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, m_ready_at = 0;
    logic [3:0] m_wptr [CH];
    logic in_rst = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        addr_q.delete(); start_q.delete(); res_q.delete(); ovr_q.delete();
        for (int i = 0; i < CH; i++) m_wptr[i] = '0;
    endtask

    // Drive one cycle: check combinational outputs, push expectations, advance.
    task automatic step(input logic nd, input logic [1:0] ch);
        logic m_rdy;
        logic [3:0] a, b;
        addr_t e;
        res_t r;
        DataNd_i = nd; DataCh_i = ch;
        #1;
        m_rdy = (cyc >= m_ready_at);
        chk("ready", Ready_o, m_rdy);
        chk("we", DataWe_o, nd & m_rdy);
        if (nd && m_rdy) begin
            chk("wr_addr", DataAddrWr_o, {ch, m_wptr[ch]});
            for (int t = 0; t < NT; t++) begin
                a = m_wptr[ch] - 4'(t);
                b = m_wptr[ch] - 4'(TAPS - 1) + 4'(t);
                e.cyc = cyc + 1 + t; e.a = {ch, a}; e.b = {ch, b}; e.c = 4'(t);
                addr_q.push_back(e);
            end
            start_q.push_back(cyc + 1 + MAC_LAT);
            r.cyc = cyc + NT + MAC_LAT + 1; r.ch = ch;
            res_q.push_back(r);
            m_wptr[ch] = m_wptr[ch] + 4'd1;
            m_ready_at = cyc + NT;
        end else if (nd) begin
            ovr_q.push_back(cyc + 1);
        end
        @(posedge Clk_i); #1;
        cyc++;
        DataNd_i = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0);
    endtask

    task automatic chk_zero_outs();
        chk("rst_avalid", AddrValid_o, 0);
        chk("rst_daddr", DataAddr_o, 0);
        chk("rst_caddr", CoeffAddr_o, 0);
        chk("rst_start", StartAcc_o, 0);
        chk("rst_dvalid", DataValid_o, 0);
        chk("rst_dch", DataCh_o, 0);
        chk("rst_ovr", Overrun_o, 0);
        chk("rst_ready", Ready_o, 1);
    endtask

    // Monitor: pop expectations whenever the DUT raises a strobe.
    always @(negedge Clk_i) begin
        if (!in_rst) begin
            if (AddrValid_o) begin
                if (addr_q.size() == 0) chk("addr_extra", 1, 0);
                else begin
                    addr_t e;
                    e = addr_q.pop_front();
                    chk("addr_cyc", cyc, e.cyc);
                    chk("data_addr", DataAddr_o, e.a);
                    chk("coeff_addr", CoeffAddr_o, e.c);
`ifdef FIR_SYM_FOLD_EN
                    chk("data_addr_b", DataAddrB_o, e.b);
`endif
                end
            end
            if (StartAcc_o) begin
                if (start_q.size() == 0) chk("start_extra", 1, 0);
                else chk("start_cyc", cyc, start_q.pop_front());
            end
            if (DataValid_o) begin
                if (res_q.size() == 0) chk("dvalid_extra", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("dvalid_cyc", cyc, r.cyc);
                    chk("data_ch", DataCh_o, r.ch);
                end
            end
            if (Overrun_o) begin
                if (ovr_q.size() == 0) chk("ovr_extra", 1, 0);
                else chk("ovr_cyc", cyc, ovr_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        RstN_i = 0;
        repeat (3) @(posedge Clk_i);
        #1 chk_zero_outs();
        #3 RstN_i = 1;
        @(posedge Clk_i); #1;
        in_rst = 0; cyc = 0; m_ready_at = 0;

        // Single sweep, overrun in cycle 5, back-to-back accept at the last tap.
        step(1'b1, 2'd0);
        idle(4);
        step(1'b1, 2'd0);
        idle(NT - 6);
        step(1'b1, 2'd0);
        idle(NT + MAC_LAT + 4);

        // Channel 2 bank, then channel 0 again.
        step(1'b1, 2'd2);
        idle(NT);
        step(1'b1, 2'd0);
        idle(NT + MAC_LAT + 3);

        // Reset mid-sweep: nothing from the aborted sweep may surface.
        step(1'b1, 2'd1);
        idle(6);
        in_rst = 1;
        RstN_i = 0;
        #1 chk_zero_outs();
        model_reset();
        @(posedge Clk_i); #1; cyc++;
        @(posedge Clk_i); #1; cyc++;
        RstN_i = 1;
        in_rst = 0;
        m_ready_at = cyc;
        step(1'b1, 2'd1);
        idle(NT + MAC_LAT + 3);

        // 17 samples on channel 0: the last one wraps to address 0.
        for (int k = 0; k < 17; k++) begin
            while (cyc < m_ready_at) step(1'b0, 2'd0);
            step(1'b1, 2'd0);
        end
        idle(NT + MAC_LAT + 3);

        // Random traffic across all channels, with overruns.
        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)));
        idle(NT + MAC_LAT + 4);

        chk("addr_q_empty", addr_q.size(), 0);
        chk("start_q_empty", start_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        chk("ovr_q_empty", ovr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
